ctrl_fsm_v2: RTL and testbench
==============================

Name: ctrl_fsm_v2

Overview:
- Second-generation control sequencer for the 8-bit accumulator CPU. Superset of the original fetch/execute FSM.
- Adds memory wait-state handshake, a bounded stack with overflow/underflow detection, one maskable interrupt (EI/DI/RTI), and HALT.
- Drives the PC, IR, AC, SP and RAM datapath strobes. Sits between instruction memory/RAM and the datapath.

Parameters:
- OPC_W, 8, opcode width; decode uses opcode[7:0], upper bits zero when OPC_W>8.
- STACK_DEPTH, 16, maximum number of stacked words.
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the depth counter.
- WAIT_EN, 1, 1: honour MEM_READY; 0: MEM_READY treated as constant 1.
- IRQ_EN, 1, 0: IRQ ignored; EI is a NOP.

Ports:
- CLK  in  1  clock; state register updates on the falling edge.
- RESET_N  in  1  asynchronous active-low reset.
- opcode  in  OPC_W  current IRU opcode.
- ZFLG, NFLG  in  1 each  ALU flags.
- MEM_READY  in  1  memory completes the access this cycle.
- IRQ  in  1  level interrupt request.
- FETCH, INC_PC, LOAD_PC, LOAD_VEC, LOAD_IRU, LOAD_IRL, LOAD_AC  out  1 each  datapath strobes; LOAD_VEC means PC <= interrupt vector.
- MEM_REQ, STORE_MEM  out  1 each  RAM request / write enable.
- LOAD_SP, SP_INC, SP_DEC, SP_ADDR, PC_TO_MEM  out  1 each  stack strobes; PC_TO_MEM selects PC as write data.
- IACK  out  1  one-cycle interrupt acknowledge.
- IE  out  1  interrupt-enable flag.
- HALTED  out  1  FSM is in HALT.
- STK_OVF, STK_UNF  out  1 each  sticky stack fault flags.
- STK_DEPTH  out  DEPTH_W  current stack occupancy.
- STATE  out  5  state encoding.

Behaviour:
- **Reset (RESET_N=0, async):**
  - State goes to START.
  - IE, STK_OVF, STK_UNF and STK_DEPTH clear to 0.
  - All strobes are 0.
- **Strobes:** combinational from state/inputs. Default 0 every cycle.
- **State encodings:** START=0, PREPU=1, FETCHU=2, PREPL=3, FETCHL=4, EXEC1=5, EXEC2=6, EXEC3=7, STORE=8, JUMP=9, LDSP=10, PUSH=11, POP1=12, JSR=13, RTS1=14, RD2=15, INT=16, HALT=17.
- **START:** go to PREPU.
- **PREPU:**
  - If IRQ_EN && IRQ && IE: go to INT.
  - Otherwise assert FETCH and MEM_REQ, then go to FETCHU.
- **Memory access states (wait-state rule):** applies to FETCHU, FETCHL, EXEC3, STORE, PUSH, JSR, INT, RD2.
  - MEM_REQ is asserted throughout.
  - Completing strobes (INC_PC, LOAD_*, SP_*, STORE_MEM, IACK) fire only in the cycle where MEM_READY=1.
  - While MEM_READY=0 the FSM holds state.
- **FETCHU:** FETCH, INC_PC, LOAD_IRU. Next state by opcode:
  - 00 (NOP), 04 (CLR) -> EXEC1.
  - 1B (EI): set IE -> PREPU.
  - 1C (DI): clear IE -> PREPU.
  - 1D -> HALT.
  - 1A (RTI) -> RTS1.
  - Any other opcode -> PREPL.
- **PREPL:** FETCH, MEM_REQ -> FETCHL.
- **FETCHL:** FETCH, INC_PC, LOAD_IRL. Next state by opcode:
  - 02, 06, 08, 0E, 0F -> EXEC2.
  - 01, 05, 07, 09–0D -> EXEC3.
  - 03 -> STORE.
  - 10–14 -> JUMP.
  - 15 -> LDSP.
  - 16 -> PUSH.
  - 17 -> POP1.
  - 18 -> JSR.
  - 19 -> RTS1.
  - Undefined -> START.
- **EXEC1, EXEC2:** LOAD_AC -> PREPU.
- **EXEC3:** on MEM_READY -> EXEC2.
- **STORE:** STORE_MEM -> PREPU.
- **JUMP:** LOAD_PC on the condition:
  - 10: always.
  - 11: NFLG.
  - 12: !NFLG.
  - 13: ZFLG.
  - 14: !ZFLG.
  - Then -> PREPU.
- **LDSP:** LOAD_SP; STK_DEPTH <= 0 -> PREPU.
- **PUSH / JSR (STK_DEPTH<STACK_DEPTH):**
  - Both: SP_DEC, SP_ADDR, STORE_MEM; depth+1.
  - JSR also: PC_TO_MEM and LOAD_PC.
  - Then -> PREPU.
- **POP1 / RTS1 (STK_DEPTH>0):** SP_ADDR, MEM_REQ -> RD2.
- **RD2:** SP_ADDR and SP_INC; depth-1. Then:
  - opcode 17: LOAD_AC.
  - opcode 19: LOAD_PC.
  - opcode 1A: LOAD_PC, set IE.
  - Then -> PREPU.
- **Stack overflow:** PUSH/JSR/INT at depth==STACK_DEPTH:
  - No strobes asserted.
  - Set STK_OVF -> HALT.
- **Stack underflow:** POP1/RTS1 at depth==0:
  - Set STK_UNF -> HALT.
- **INT (normal case):**
  - SP_DEC, SP_ADDR, PC_TO_MEM, STORE_MEM, LOAD_VEC, IACK.
  - Clear IE; depth+1 -> PREPU.
- **INT overflow case:** depth==STACK_DEPTH follows the overflow rule; IACK stays 0.
- **HALT:** HALTED=1.
  - Exit to INT when IRQ_EN && IRQ && IE && !STK_OVF && !STK_UNF.
  - Otherwise only reset exits HALT.
- **Depth counter:** saturating; never wraps.
- **Same-cycle events:**
  - EI executed immediately before PREPU permits interrupt entry at that PREPU.
  - IRQ is not sampled in any state other than PREPU and HALT.

Test Plan:
- **Reset and fetch:** RESET_N low mid-FETCHL with MEM_READY=1, opcode 02 -> STATE=0 immediately; after release, the sequence is 0,1,2,3,4,6,1 and LOAD_AC pulses once.
- **Wait states:** MEM_READY low for 3 cycles during FETCHU -> STATE holds at 2 for 3 cycles; LOAD_IRU/INC_PC are asserted only in the 4th cycle.
- **Stack round trip:** LOADSP, then PUSH×3 -> STK_DEPTH=3 with SP_DEC ×3; POP×3 -> depth=0 with LOAD_AC ×3; a 4th POP sets STK_UNF and HALTED=1, with no SP_INC.
- **Overflow:** STACK_DEPTH=2, JSR×3 -> the 3rd JSR gives STORE_MEM=0, LOAD_PC=0, STK_OVF=1, STATE=17.
- **Interrupt:** EI, then IRQ=1 -> the next PREPU enters INT; IACK is a single-cycle pulse with LOAD_VEC and PC_TO_MEM, and IE=0; RTI then gives LOAD_PC, IE=1 and depth restored.
- **Jumps:** opcode 13 with ZFLG=0 -> LOAD_PC=0; with ZFLG=1 -> LOAD_PC=1; opcode 12 with NFLG=1 -> no load.

Source files
------------

// File: rtl/ctrl_fsm_v2_if.sv
// rtl/ctrl_fsm_v2_if.sv - handshake and strobe bundle between the sequencer and the datapath
interface ctrl_fsm_v2_if #(
  parameter int OPC_W   = 8,
  parameter int DEPTH_W = 5
);
  logic [OPC_W-1:0]   opcode;
  logic               ZFLG;
  logic               NFLG;
  logic               MEM_READY;
  logic               IRQ;
  logic               FETCH;
  logic               INC_PC;
  logic               LOAD_PC;
  logic               LOAD_VEC;
  logic               LOAD_IRU;
  logic               LOAD_IRL;
  logic               LOAD_AC;
  logic               MEM_REQ;
  logic               STORE_MEM;
  logic               LOAD_SP;
  logic               SP_INC;
  logic               SP_DEC;
  logic               SP_ADDR;
  logic               PC_TO_MEM;
  logic               IACK;
  logic               IE;
  logic               HALTED;
  logic               STK_OVF;
  logic               STK_UNF;
  logic [DEPTH_W-1:0] STK_DEPTH;
  logic [4:0]         STATE;

  // Sequencer side: consumes opcode/flags/handshake, drives every strobe.
  modport master (
    input  opcode, ZFLG, NFLG, MEM_READY, IRQ,
    output FETCH, INC_PC, LOAD_PC, LOAD_VEC, LOAD_IRU, LOAD_IRL, LOAD_AC,
           MEM_REQ, STORE_MEM, LOAD_SP, SP_INC, SP_DEC, SP_ADDR, PC_TO_MEM,
           IACK, IE, HALTED, STK_OVF, STK_UNF, STK_DEPTH, STATE
  );

  // Datapath/memory side.
  modport slave (
    output opcode, ZFLG, NFLG, MEM_READY, IRQ,
    input  FETCH, INC_PC, LOAD_PC, LOAD_VEC, LOAD_IRU, LOAD_IRL, LOAD_AC,
           MEM_REQ, STORE_MEM, LOAD_SP, SP_INC, SP_DEC, SP_ADDR, PC_TO_MEM,
           IACK, IE, HALTED, STK_OVF, STK_UNF, STK_DEPTH, STATE
  );
endinterface

// File: rtl/ctrl_fsm_v2.sv
// rtl/ctrl_fsm_v2.sv - fetch/execute sequencer with wait states, bounded stack, interrupt and halt
module ctrl_fsm_v2 #(
  parameter int OPC_W       = 8,
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1),
  parameter bit WAIT_EN     = 1'b1,
  parameter bit IRQ_EN      = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  ctrl_fsm_v2_if.master bus
);

  typedef enum logic [4:0] {
    START  = 5'd0,  PREPU  = 5'd1,  FETCHU = 5'd2,  PREPL = 5'd3,
    FETCHL = 5'd4,  EXEC1  = 5'd5,  EXEC2  = 5'd6,  EXEC3 = 5'd7,
    STORE  = 5'd8,  JUMP   = 5'd9,  LDSP   = 5'd10, PUSH  = 5'd11,
    POP1   = 5'd12, JSR    = 5'd13, RTS1   = 5'd14, RD2   = 5'd15,
    INT    = 5'd16, HALT   = 5'd17
  } state_t;

  state_t             state_q, state_d;
  logic               ie_q, ie_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [OPC_W-1:0]   opc_full;
  logic [7:0]         op;
  logic               rdy;
  logic               irq_take;
  logic               full;
  logic               empty;

  assign opc_full = bus.opcode;
  assign op       = opc_full[7:0];
  // With wait states disabled every memory access completes in one cycle.
  assign rdy      = WAIT_EN ? bus.MEM_READY : 1'b1;
  assign irq_take = IRQ_EN && bus.IRQ && ie_q;
  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);

  assign bus.STATE     = state_q;
  assign bus.HALTED    = (state_q == HALT);
  assign bus.IE        = ie_q;
  assign bus.STK_OVF   = ovf_q;
  assign bus.STK_UNF   = unf_q;
  assign bus.STK_DEPTH = depth_q;

  // State and sticky status registers, updated on the falling clock edge.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= START;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      depth_q <= depth_d;
    end
  end

  // Next-state and strobe decode; memory states hold until rdy and only then fire completing strobes.
  always_comb begin
    state_d       = state_q;
    ie_d          = ie_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    depth_d       = depth_q;
    bus.FETCH     = 1'b0;
    bus.INC_PC    = 1'b0;
    bus.LOAD_PC   = 1'b0;
    bus.LOAD_VEC  = 1'b0;
    bus.LOAD_IRU  = 1'b0;
    bus.LOAD_IRL  = 1'b0;
    bus.LOAD_AC   = 1'b0;
    bus.MEM_REQ   = 1'b0;
    bus.STORE_MEM = 1'b0;
    bus.LOAD_SP   = 1'b0;
    bus.SP_INC    = 1'b0;
    bus.SP_DEC    = 1'b0;
    bus.SP_ADDR   = 1'b0;
    bus.PC_TO_MEM = 1'b0;
    bus.IACK      = 1'b0;
    case (state_q)
      START: state_d = PREPU;
      PREPU: begin
        if (irq_take) begin
          state_d = INT;
        end else begin
          bus.FETCH   = 1'b1;
          bus.MEM_REQ = 1'b1;
          state_d     = FETCHU;
        end
      end
      FETCHU: begin
        bus.FETCH   = 1'b1;
        bus.MEM_REQ = 1'b1;
        if (rdy) begin
          bus.INC_PC   = 1'b1;
          bus.LOAD_IRU = 1'b1;
          case (op)
            8'h00, 8'h04: state_d = EXEC1;
            8'h1B: begin
              if (IRQ_EN) ie_d = 1'b1;
              state_d = PREPU;
            end
            8'h1C: begin
              ie_d    = 1'b0;
              state_d = PREPU;
            end
            8'h1D:   state_d = HALT;
            8'h1A:   state_d = RTS1;
            default: state_d = PREPL;
          endcase
        end
      end
      PREPL: begin
        bus.FETCH   = 1'b1;
        bus.MEM_REQ = 1'b1;
        state_d     = FETCHL;
      end
      FETCHL: begin
        bus.FETCH   = 1'b1;
        bus.MEM_REQ = 1'b1;
        if (rdy) begin
          bus.INC_PC   = 1'b1;
          bus.LOAD_IRL = 1'b1;
          case (op)
            8'h02, 8'h06, 8'h08, 8'h0E, 8'h0F:                      state_d = EXEC2;
            8'h01, 8'h05, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D: state_d = EXEC3;
            8'h03:                                                  state_d = STORE;
            8'h10, 8'h11, 8'h12, 8'h13, 8'h14:                      state_d = JUMP;
            8'h15:   state_d = LDSP;
            8'h16:   state_d = PUSH;
            8'h17:   state_d = POP1;
            8'h18:   state_d = JSR;
            8'h19:   state_d = RTS1;
            default: state_d = START;
          endcase
        end
      end
      EXEC1, EXEC2: begin
        bus.LOAD_AC = 1'b1;
        state_d     = PREPU;
      end
      EXEC3: begin
        bus.MEM_REQ = 1'b1;
        if (rdy) state_d = EXEC2;
      end
      STORE: begin
        bus.MEM_REQ = 1'b1;
        if (rdy) begin
          bus.STORE_MEM = 1'b1;
          state_d       = PREPU;
        end
      end
      JUMP: begin
        case (op)
          8'h10:   bus.LOAD_PC = 1'b1;
          8'h11:   bus.LOAD_PC = bus.NFLG;
          8'h12:   bus.LOAD_PC = !bus.NFLG;
          8'h13:   bus.LOAD_PC = bus.ZFLG;
          8'h14:   bus.LOAD_PC = !bus.ZFLG;
          default: bus.LOAD_PC = 1'b0;
        endcase
        state_d = PREPU;
      end
      LDSP: begin
        bus.LOAD_SP = 1'b1;
        depth_d     = '0;
        state_d     = PREPU;
      end
      PUSH, JSR: begin
        if (full) begin
          ovf_d   = 1'b1;
          state_d = HALT;
        end else begin
          bus.MEM_REQ   = 1'b1;
          bus.PC_TO_MEM = (state_q == JSR);
          if (rdy) begin
            bus.SP_DEC    = 1'b1;
            bus.SP_ADDR   = 1'b1;
            bus.STORE_MEM = 1'b1;
            bus.LOAD_PC   = (state_q == JSR);
            depth_d       = depth_q + 1'b1;
            state_d       = PREPU;
          end
        end
      end
      POP1, RTS1: begin
        if (empty) begin
          unf_d   = 1'b1;
          state_d = HALT;
        end else begin
          bus.SP_ADDR = 1'b1;
          bus.MEM_REQ = 1'b1;
          state_d     = RD2;
        end
      end
      RD2: begin
        bus.MEM_REQ = 1'b1;
        if (rdy) begin
          bus.SP_ADDR = 1'b1;
          bus.SP_INC  = 1'b1;
          if (!empty) depth_d = depth_q - 1'b1;
          case (op)
            8'h17: bus.LOAD_AC = 1'b1;
            8'h19: bus.LOAD_PC = 1'b1;
            8'h1A: begin
              bus.LOAD_PC = 1'b1;
              ie_d        = 1'b1;
            end
            default: ;
          endcase
          state_d = PREPU;
        end
      end
      INT: begin
        if (full) begin
          ovf_d   = 1'b1;
          state_d = HALT;
        end else begin
          bus.MEM_REQ   = 1'b1;
          bus.PC_TO_MEM = 1'b1;
          if (rdy) begin
            bus.SP_DEC    = 1'b1;
            bus.SP_ADDR   = 1'b1;
            bus.STORE_MEM = 1'b1;
            bus.LOAD_VEC  = 1'b1;
            bus.IACK      = 1'b1;
            ie_d          = 1'b0;
            depth_d       = depth_q + 1'b1;
            state_d       = PREPU;
          end
        end
      end
      HALT: begin
        if (irq_take && !ovf_q && !unf_q) state_d = INT;
      end
      default: state_d = START;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm_v2.sv
// tb/tb_ctrl_fsm_v2.sv - directed scoreboard bench for ctrl_fsm_v2
module tb_ctrl_fsm_v2;
  localparam int OPC_W       = 8;
  localparam int STACK_DEPTH = 16;
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

  localparam logic [4:0] ST_START = 5'd0,  ST_PREPU = 5'd1,  ST_FETCHU = 5'd2, ST_PREPL = 5'd3;
  localparam logic [4:0] ST_FETCHL = 5'd4, ST_EXEC1 = 5'd5,  ST_EXEC2 = 5'd6,  ST_EXEC3 = 5'd7;
  localparam logic [4:0] ST_STORE = 5'd8,  ST_JUMP = 5'd9,   ST_LDSP = 5'd10,  ST_PUSH = 5'd11;
  localparam logic [4:0] ST_POP1 = 5'd12,  ST_JSR = 5'd13,   ST_RTS1 = 5'd14,  ST_RD2 = 5'd15;
  localparam logic [4:0] ST_INT = 5'd16,   ST_HALT = 5'd17;

  // Strobe bit positions in the packed observation vector.
  localparam logic [14:0] S_FETCH = 15'h4000, S_INC_PC = 15'h2000, S_LOAD_PC = 15'h1000;
  localparam logic [14:0] S_LOAD_VEC = 15'h0800, S_LOAD_IRU = 15'h0400, S_LOAD_IRL = 15'h0200;
  localparam logic [14:0] S_LOAD_AC = 15'h0100, S_MEM_REQ = 15'h0080, S_STORE_MEM = 15'h0040;
  localparam logic [14:0] S_LOAD_SP = 15'h0020, S_SP_INC = 15'h0010, S_SP_DEC = 15'h0008;
  localparam logic [14:0] S_SP_ADDR = 15'h0004, S_PC_TO_MEM = 15'h0002, S_IACK = 15'h0001;
  localparam logic [14:0] S_NONE = 15'h0000;

  localparam logic [14:0] SB_PREP = S_FETCH | S_MEM_REQ;
  localparam logic [14:0] SB_FU   = S_FETCH | S_MEM_REQ | S_INC_PC | S_LOAD_IRU;
  localparam logic [14:0] SB_FL   = S_FETCH | S_MEM_REQ | S_INC_PC | S_LOAD_IRL;
  localparam logic [14:0] SB_PUSH = S_MEM_REQ | S_SP_DEC | S_SP_ADDR | S_STORE_MEM;
  localparam logic [14:0] SB_JSR  = SB_PUSH | S_PC_TO_MEM | S_LOAD_PC;
  localparam logic [14:0] SB_POP1 = S_MEM_REQ | S_SP_ADDR;
  localparam logic [14:0] SB_RD2  = S_MEM_REQ | S_SP_ADDR | S_SP_INC;
  localparam logic [14:0] SB_INT  = S_MEM_REQ | S_SP_DEC | S_SP_ADDR | S_PC_TO_MEM | S_STORE_MEM | S_LOAD_VEC | S_IACK;

  localparam int SIG_STATE = 0, SIG_STB = 1, SIG_IE = 2, SIG_HALTED = 3, SIG_OVF = 4, SIG_UNF = 5, SIG_DEPTH = 6;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;

  ctrl_fsm_v2_if #(.OPC_W(OPC_W), .DEPTH_W(DEPTH_W)) bus ();

  ctrl_fsm_v2 #(
    .OPC_W(OPC_W), .STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W), .WAIT_EN(1'b1), .IRQ_EN(1'b1)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [14:0] strobes;
  assign strobes = {bus.FETCH, bus.INC_PC, bus.LOAD_PC, bus.LOAD_VEC, bus.LOAD_IRU, bus.LOAD_IRL,
                    bus.LOAD_AC, bus.MEM_REQ, bus.STORE_MEM, bus.LOAD_SP, bus.SP_INC, bus.SP_DEC,
                    bus.SP_ADDR, bus.PC_TO_MEM, bus.IACK};

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_STATE:  return 32'(bus.STATE);
      SIG_STB:    return 32'(strobes);
      SIG_IE:     return 32'(bus.IE);
      SIG_HALTED: return 32'(bus.HALTED);
      SIG_OVF:    return 32'(bus.STK_OVF);
      SIG_UNF:    return 32'(bus.STK_UNF);
      SIG_DEPTH:  return 32'(bus.STK_DEPTH);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic want(input string tag, input int sig, input logic [31:0] val);
    sb.push_back('{tag, sig, val});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sig);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  // One cycle: drive inputs just after the inactive edge, then check well before the falling edge.
  task automatic step(input string tag, input logic [7:0] op, input logic rdy, input logic irq,
                      input logic [1:0] zn, input logic [4:0] st, input logic [14:0] stb);
    @(posedge CLK);
    #1;
    bus.opcode    = op;
    bus.MEM_READY = rdy;
    bus.IRQ       = irq;
    bus.ZFLG      = zn[1];
    bus.NFLG      = zn[0];
    want({tag, ":state"}, SIG_STATE, 32'(st));
    want({tag, ":strobes"}, SIG_STB, 32'(stb));
    #1;
    drain();
  endtask

  task automatic fetch1(input string tag, input logic [7:0] op);
    step({tag, ":prepu"}, op, 1'b1, 1'b0, 2'b00, ST_PREPU, SB_PREP);
    step({tag, ":fetchu"}, op, 1'b1, 1'b0, 2'b00, ST_FETCHU, SB_FU);
  endtask

  task automatic fetch2(input string tag, input logic [7:0] op);
    fetch1(tag, op);
    step({tag, ":prepl"}, op, 1'b1, 1'b0, 2'b00, ST_PREPL, SB_PREP);
    step({tag, ":fetchl"}, op, 1'b1, 1'b0, 2'b00, ST_FETCHL, SB_FL);
  endtask

  task automatic reset_cycle(input string tag);
    RESET_N = 1'b0;
    want({tag, ":ie"}, SIG_IE, 32'd0);
    want({tag, ":ovf"}, SIG_OVF, 32'd0);
    want({tag, ":unf"}, SIG_UNF, 32'd0);
    want({tag, ":depth"}, SIG_DEPTH, 32'd0);
    want({tag, ":halted"}, SIG_HALTED, 32'd0);
    step(tag, 8'h00, 1'b1, 1'b0, 2'b00, ST_START, S_NONE);
    RESET_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode    = '0;
    bus.MEM_READY = 1'b1;
    bus.IRQ       = 1'b0;
    bus.ZFLG      = 1'b0;
    bus.NFLG      = 1'b0;
    RESET_N       = 1'b0;

    // Reset state, then async reset landing in the middle of FETCHL.
    step("rst_hold", 8'h00, 1'b1, 1'b0, 2'b00, ST_START, S_NONE);
    reset_cycle("rst0");
    fetch2("pre", 8'h02);
    RESET_N = 1'b0;
    #1;
    want("rst_async:state", SIG_STATE, 32'(ST_START));
    want("rst_async:strobes", SIG_STB, 32'(S_NONE));
    drain();
    reset_cycle("rst1");

    // 0,1,2,3,4,6,1 with a single LOAD_AC.
    fetch2("ldi", 8'h02);
    step("ldi:exec2", 8'h02, 1'b1, 1'b0, 2'b00, ST_EXEC2, S_LOAD_AC);

    // Three wait cycles in FETCHU, completion on the fourth.
    step("wait:prepu", 8'h00, 1'b1, 1'b0, 2'b00, ST_PREPU, SB_PREP);
    for (int i = 0; i < 3; i++)
      step("wait:hold", 8'h00, 1'b0, 1'b0, 2'b00, ST_FETCHU, SB_PREP);
    step("wait:done", 8'h00, 1'b1, 1'b0, 2'b00, ST_FETCHU, SB_FU);
    step("wait:exec1", 8'h00, 1'b1, 1'b0, 2'b00, ST_EXEC1, S_LOAD_AC);

    // Memory-operand exec with a wait, store, undefined opcode.
    fetch2("add", 8'h01);
    step("add:exec3w", 8'h01, 1'b0, 1'b0, 2'b00, ST_EXEC3, S_MEM_REQ);
    step("add:exec3", 8'h01, 1'b1, 1'b0, 2'b00, ST_EXEC3, S_MEM_REQ);
    step("add:exec2", 8'h01, 1'b1, 1'b0, 2'b00, ST_EXEC2, S_LOAD_AC);
    fetch2("sta", 8'h03);
    step("sta:store", 8'h03, 1'b1, 1'b0, 2'b00, ST_STORE, S_MEM_REQ | S_STORE_MEM);
    fetch2("undef", 8'h20);
    step("undef:start", 8'h20, 1'b1, 1'b0, 2'b00, ST_START, S_NONE);

    // Conditional jumps.
    fetch2("jz0", 8'h13);
    step("jz0:jump", 8'h13, 1'b1, 1'b0, 2'b00, ST_JUMP, S_NONE);
    fetch2("jz1", 8'h13);
    step("jz1:jump", 8'h13, 1'b1, 1'b0, 2'b10, ST_JUMP, S_LOAD_PC);
    fetch2("jp", 8'h12);
    step("jp:jump", 8'h12, 1'b1, 1'b0, 2'b01, ST_JUMP, S_NONE);
    fetch2("jn", 8'h11);
    step("jn:jump", 8'h11, 1'b1, 1'b0, 2'b01, ST_JUMP, S_LOAD_PC);

    // EI then IRQ: interrupt taken at the very next PREPU, then RTI.
    fetch1("ei", 8'h1B);
    want("ei:ie", SIG_IE, 32'd1);
    step("irq:prepu", 8'h00, 1'b1, 1'b1, 2'b00, ST_PREPU, S_NONE);
    step("irq:wait", 8'h00, 1'b0, 1'b1, 2'b00, ST_INT, S_MEM_REQ | S_PC_TO_MEM);
    step("irq:ack", 8'h00, 1'b1, 1'b1, 2'b00, ST_INT, SB_INT);
    want("irq:ie", SIG_IE, 32'd0);
    want("irq:depth", SIG_DEPTH, 32'd1);
    step("rti:prepu", 8'h1A, 1'b1, 1'b1, 2'b00, ST_PREPU, SB_PREP);
    step("rti:fetchu", 8'h1A, 1'b1, 1'b0, 2'b00, ST_FETCHU, SB_FU);
    step("rti:rts1", 8'h1A, 1'b1, 1'b0, 2'b00, ST_RTS1, SB_POP1);
    step("rti:rd2", 8'h1A, 1'b1, 1'b0, 2'b00, ST_RD2, SB_RD2 | S_LOAD_PC);
    want("rti:ie", SIG_IE, 32'd1);
    want("rti:depth", SIG_DEPTH, 32'd0);
    fetch1("di", 8'h1C);
    want("di:ie", SIG_IE, 32'd0);

    // HALT left only through an enabled interrupt.
    fetch1("ei2", 8'h1B);
    fetch1("hlt", 8'h1D);
    want("hlt:halted", SIG_HALTED, 32'd1);
    step("hlt:idle", 8'h00, 1'b1, 1'b0, 2'b00, ST_HALT, S_NONE);
    step("hlt:irq", 8'h00, 1'b1, 1'b1, 2'b00, ST_HALT, S_NONE);
    step("hlt:int", 8'h00, 1'b1, 1'b0, 2'b00, ST_INT, SB_INT);
    want("hlt:depth", SIG_DEPTH, 32'd1);

    // Stack round trip and underflow.
    fetch2("ldsp", 8'h15);
    step("ldsp:ldsp", 8'h15, 1'b1, 1'b0, 2'b00, ST_LDSP, S_LOAD_SP);
    want("ldsp:depth", SIG_DEPTH, 32'd0);
    for (int i = 0; i < 3; i++) begin
      fetch2("push", 8'h16);
      step("push:push", 8'h16, 1'b1, 1'b0, 2'b00, ST_PUSH, SB_PUSH);
    end
    want("push:depth", SIG_DEPTH, 32'd3);
    for (int i = 0; i < 3; i++) begin
      fetch2("pop", 8'h17);
      step("pop:pop1", 8'h17, 1'b1, 1'b0, 2'b00, ST_POP1, SB_POP1);
      step("pop:rd2", 8'h17, 1'b1, 1'b0, 2'b00, ST_RD2, SB_RD2 | S_LOAD_AC);
    end
    want("pop:depth", SIG_DEPTH, 32'd0);
    fetch2("unf", 8'h17);
    step("unf:pop1", 8'h17, 1'b1, 1'b0, 2'b00, ST_POP1, S_NONE);
    want("unf:flag", SIG_UNF, 32'd1);
    want("unf:halted", SIG_HALTED, 32'd1);
    step("unf:halt", 8'h17, 1'b1, 1'b1, 2'b00, ST_HALT, S_NONE);
    RESET_N = 1'b0;
    reset_cycle("rst2");

    // Overflow: JSR beyond the stack depth.
    fetch2("ldsp2", 8'h15);
    step("ldsp2:ldsp", 8'h15, 1'b1, 1'b0, 2'b00, ST_LDSP, S_LOAD_SP);
    for (int i = 0; i < STACK_DEPTH; i++) begin
      fetch2("jsr", 8'h18);
      step("jsr:jsr", 8'h18, 1'b1, 1'b0, 2'b00, ST_JSR, SB_JSR);
    end
    want("jsr:depth", SIG_DEPTH, 32'(STACK_DEPTH));
    fetch2("ovf", 8'h18);
    step("ovf:jsr", 8'h18, 1'b1, 1'b0, 2'b00, ST_JSR, S_NONE);
    want("ovf:flag", SIG_OVF, 32'd1);
    want("ovf:depth", SIG_DEPTH, 32'(STACK_DEPTH));
    step("ovf:halt", 8'h00, 1'b1, 1'b0, 2'b00, ST_HALT, S_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
